fp8_to_twos: RTL
================

Name: fp8_to_twos

Overview:
- Reverse-direction partner of the two's-complement-to-floating-point converter.
- Accepts one 8-bit float (sign, 3-bit exponent, 4-bit significand) over a valid/ready handshake.
- Rebuilds the value V = (-1)^S * F * 2^E as a 12-bit two's-complement word, using a sequential shift-left loop (one shift per cycle) and a final negate step.
- Sits at the output side of the FP datapath and feeds 12-bit integer consumers; one conversion in flight at a time.

Parameters:
- EXP_W, 3, exponent width; shift count ranges 0..2^EXP_W-1.
- FRAC_W, 4, significand width.
- OUT_W, 12, output word width.
- Legality constraint: FRAC_W + 2^EXP_W - 1 <= OUT_W - 1. The defaults give 11 <= 11, so no overflow is possible.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input float valid
- in_ready  out  1  block can accept a float (IDLE only)
- in_sign  in  1  sign S
- in_exp  in  EXP_W  exponent E
- in_frac  in  FRAC_W  significand F (unsigned, no hidden bit)
- out_valid  out  1  out_data holds a completed result
- out_ready  in  1  consumer accepts the result
- out_data  out  OUT_W  two's-complement result
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async assert, sync release): state=IDLE, in_ready=1, out_valid=0, out_data=0, busy=0, internal mag/cnt/sign=0.
- FSM states: IDLE, SHIFT, CONV, OUT.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: capture sign<=in_sign, cnt<=in_exp, mag<=zero-extended in_frac (OUT_W bits), then go to SHIFT.
- SHIFT:
  - If cnt!=0: mag<=mag<<1 and cnt<=cnt-1; stay in SHIFT.
  - If cnt==0: go to CONV.
  - E shift cycles plus one exit cycle.
- CONV:
  - out_data<=sign ? (~mag+1) : mag, truncated to OUT_W.
  - out_valid<=1; go to OUT.
  - S=1 with F=0 yields 0; negative zero is never produced.
- OUT:
  - Hold out_data and out_valid stable while out_ready=0.
  - On out_ready=1: out_valid<=0, go to IDLE.
  - in_ready is not asserted in the same cycle, so there is no bypass.
- Latency: out_valid rises E+2 clock edges after the accepting edge (E=0 gives 2, E=7 gives 9).
- Throughput: at most one result per E+4 cycles with out_ready tied high.
- in_valid while busy is ignored: in_ready=0, and inputs are sampled only on the accepting edge. Input fields may change freely after acceptance.
- out_data keeps its last value after the handshake until the next CONV. Consumers qualify it with out_valid only.
- out_ready while out_valid=0 has no effect.
- Reset asserted in any state aborts the conversion immediately and returns all outputs to their reset values; no partial result is ever presented.
- cnt is EXP_W wide and never wraps, because it only decrements while nonzero.

Decomposition:
- Shared package fp8_pkg holds:
  - EXP_W, FRAC_W, OUT_W defaults;
  - the state enum {IDLE, SHIFT, CONV, OUT};
  - a packed fp8 struct {sign, exp, frac}, reused by the forward converter's output.
- One natural sub-module, twos_negate: combinational, OUT_W wide, conditional two's-complement negate used in CONV.
- Shifter, counter and FSM stay in the top module.

Test Plan:
- Reset, then S=0,E=0,F=0 -> out_data=0x000, out_valid high 2 edges after accept; S=1,E=0,F=0 -> 0x000 (no negative zero).
- S=0,E=7,F=15 -> out_data=0x780 (1920), latency exactly 9 edges; S=1,E=7,F=15 -> 0x880 (-1920).
- S=1,E=3,F=9 -> 0xFB8 (-72); S=0,E=1,F=8 -> 0x010 (16); S=1,E=0,F=1 -> 0xFFF (-1).
- Backpressure: S=0,E=2,F=5 with out_ready=0 for 6 cycles -> out_data=0x014 held stable and out_valid=1 throughout; out_valid drops the cycle after out_ready=1. A new in_valid pulse during OUT is not accepted (in_ready=0), and the next conversion starts only from IDLE.
- Reset mid-operation: accept S=0,E=6,F=3, assert rst_n=0 on the third SHIFT cycle -> out_valid=0, out_data=0x000, in_ready=1 immediately. The next input S=0,E=1,F=1 converts to 0x002.
- Exhaustive sweep: all 256 {S,E,F} combinations back-to-back with out_ready=1 -> each result equals the reference model (-1)^S*F*2^E (12-bit) and each latency equals E+2.

Source files
------------

// File: rtl/fp8_pkg.sv
// Shared definitions for the 8-bit float datapath.
// Holds the default field widths, the fp8_to_twos FSM state type and the packed fp8 word.
// The forward converter reuses the fp8 struct on its output.
package fp8_pkg;

    localparam int unsigned EXP_W_DEF  = 3;
    localparam int unsigned FRAC_W_DEF = 4;
    localparam int unsigned OUT_W_DEF  = 12;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StConv,
        StOut
    } state_e;

    // The significand has no hidden bit: the value is (-1)^sign * frac * 2^exp.
    typedef struct packed {
        logic                  sign;
        logic [EXP_W_DEF-1:0]  exp;
        logic [FRAC_W_DEF-1:0] frac;
    } fp8_t;

endpackage

// File: rtl/twos_negate.sv
// Conditional two's-complement negate (combinational).
// Ports:
//   neg - when high, y = -a (mod 2^WIDTH); otherwise y = a
//   a   - input word
//   y   - result word
module twos_negate #(
    parameter int unsigned WIDTH = 12
) (
    input  logic             neg,
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] y
);

    // A zero magnitude negates to zero, so negative zero cannot appear.
    assign y = neg ? (~a + WIDTH'(1)) : a;

endmodule

// File: rtl/fp8_to_twos.sv
// Converts one 8-bit float (sign, exponent, significand) into a two's-complement word.
// The significand is shifted left once per cycle, exponent times, then conditionally negated.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   in_valid, in_ready  - input handshake (in_ready only while idle)
//   in_sign, in_exp,
//   in_frac             - float fields, sampled on the accepting edge only
//   out_valid, out_ready- output handshake; out_data held while out_valid && !out_ready
//   out_data            - two's-complement result, keeps its last value after the handshake
//   busy                - high whenever a conversion is in flight
// Widths must satisfy FRAC_W + 2^EXP_W - 1 <= OUT_W - 1 so the shifted magnitude never overflows.
module fp8_to_twos
    import fp8_pkg::*;
#(
    parameter int unsigned EXP_W  = EXP_W_DEF,
    parameter int unsigned FRAC_W = FRAC_W_DEF,
    parameter int unsigned OUT_W  = OUT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic [FRAC_W-1:0] in_frac,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic              busy
);

    state_e             state_q, state_d;
    logic [OUT_W-1:0]   mag_q, mag_d;
    logic [EXP_W-1:0]   cnt_q, cnt_d;
    logic               sign_q, sign_d;
    logic [OUT_W-1:0]   out_data_q, out_data_d;
    logic               out_valid_q, out_valid_d;
    logic [OUT_W-1:0]   signed_mag;

    twos_negate #(
        .WIDTH (OUT_W)
    ) u_negate (
        .neg (sign_q),
        .a   (mag_q),
        .y   (signed_mag)
    );

    always_comb begin
        state_d     = state_q;
        mag_d       = mag_q;
        cnt_d       = cnt_q;
        sign_d      = sign_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    sign_d  = in_sign;
                    cnt_d   = in_exp;
                    mag_d   = OUT_W'(in_frac);
                    state_d = StShift;
                end
            end
            StShift: begin
                // cnt only decrements while nonzero, so it never wraps.
                if (cnt_q != '0) begin
                    mag_d = mag_q << 1;
                    cnt_d = cnt_q - EXP_W'(1);
                end else begin
                    state_d = StConv;
                end
            end
            StConv: begin
                out_data_d  = signed_mag;
                out_valid_d = 1'b1;
                state_d     = StOut;
            end
            StOut: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            mag_q       <= '0;
            cnt_q       <= '0;
            sign_q      <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mag_q       <= mag_d;
            cnt_q       <= cnt_d;
            sign_q      <= sign_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule
